count_serial_tx: RTL and testbench
==================================

// Module: count_serial_tx
// PURPOSE
//   Serial read-out transmitter for the 8-bit counter value. On a start request it
//   snapshots count_in and shifts it off-chip MSB-first on a 3-wire SPI-style link
//   (cs_n, sclk, sdo), optionally followed by an even-parity bit.
//   Sits beside counter8 in tt_um_example. Drives uio_out pins with uio_oe=1.
// PARAMETERS
//   WIDTH    8  data bits per frame (>=1)
//   CLK_DIV  4  half-period of sclk in clk cycles (>=1); bit period = 2*CLK_DIV cycles
//   PARITY   0  1: append one even-parity bit after the data bits; 0: data bits only
// PORTS
//   clk       in   1      system clock, all logic rising-edge
//   rst_n     in   1      asynchronous, active-low reset
//   ena       in   1      clock enable; 0 freezes all state and outputs
//   start     in   1      frame request, level-sampled while busy=0
//   count_in  in   WIDTH  value to transmit, sampled on the accept cycle only
//   cs_n      out  1      frame select, low for the whole frame
//   sclk      out  1      serial clock; receiver samples sdo on sclk rising edge
//   sdo       out  1      serial data
//   busy      out  1      high while a frame is in progress
//   done      out  1      one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset (async assert, sync release): cs_n=1, sclk=0, sdo=0, busy=0, done=0,
//     shift register and counters cleared, FSM=IDLE. Reset mid-frame aborts the
//     frame immediately. No done pulse is issued.
//   ena=0: all registers hold, start is ignored, and outputs hold their values.
//   FSM: IDLE -> SHIFT -> IDLE.
//   IDLE: when start=1 and ena=1 in cycle N (accept):
//     - shreg <= count_in
//     - par <= ^count_in
//     - at N+1: FSM=SHIFT, cs_n=0, busy=1, sdo=count_in[WIDTH-1], sclk=0
//   SHIFT: NBITS = WIDTH+PARITY bit periods, each of 2*CLK_DIV cycles.
//     - sclk=0 for the first CLK_DIV cycles of a bit period, then 1 for the next CLK_DIV.
//     - sdo changes only at the start of a bit period, while sclk=0.
//     - data bits are sent MSB first; if PARITY=1, the final bit is par (even parity).
//   End of frame: the cycle after the last bit period ends:
//     - FSM=IDLE, cs_n=1, sclk=0, sdo=0, busy=0, done=1 (for that cycle only)
//   Frame length: busy is high for exactly NBITS*2*CLK_DIV cycles.
//   start while busy=1: ignored, not queued. start may be accepted in the done cycle.
//     Back-to-back frames therefore have cs_n high for exactly 1 cycle between them.
//   count_in changes during SHIFT: no effect on the frame in flight.
//   Counters:
//     - div counter width $clog2(CLK_DIV)+1, wraps at CLK_DIV-1
//     - bit counter width $clog2(NBITS)+1, terminal value NBITS-1
//   No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//   Shared package count_pkg:
//     - state enum {ST_IDLE, ST_SHIFT}
//     - default constants CNT_WIDTH=8 and TX_CLK_DIV=4
//   Sub-module sclk_phase_gen (CLK_DIV):
//     - inputs: clk, rst_n, ena, run
//     - outputs: sclk, bit_start pulse, bit_end pulse
//     - counter held at 0 while run=0
//   Top FSM, shift register, parity and bit counter live in count_serial_tx.
// TESTING
//   1) Reset, then start=1 with count_in=8'hA5 (CLK_DIV=4, PARITY=0):
//      sdo sampled on sclk rising edges = 1,0,1,0,0,1,0,1; busy high 64 cycles; done pulses once.
//   2) PARITY=1, count_in=8'h07: 9 bits captured = 0000_0111 followed by parity 1;
//      busy high 72 cycles.
//   3) start held high continuously, count_in 8'h01 then 8'h02:
//      back-to-back frames; cs_n high exactly 1 cycle between them; frame 2 carries 8'h02.
//   4) Mid-frame, change count_in and pulse start:
//      frame content unchanged; no second frame starts.
//   5) Deassert ena for 10 cycles during bit 3:
//      all outputs frozen; frame resumes and total busy = 64+10 cycles.
//   6) Assert rst_n=0 during bit 5:
//      cs_n=1, busy=0, sclk=0 immediately (asynchronous); no done pulse;
//      the next start sends a complete fresh frame.

Source files
------------

// File: rtl/count_pkg.sv
// ---------------------------------------------------------------------------
// count_pkg
//   Shared definitions for the counter read-out path.
//   - state_t     : transmitter FSM states (idle / shifting a frame)
//   - CNT_WIDTH   : default counter / frame data width
//   - TX_CLK_DIV  : default sclk half-period in system clock cycles
// ---------------------------------------------------------------------------
package count_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int CNT_WIDTH  = 8;
    localparam int TX_CLK_DIV = 4;

endpackage

// File: rtl/sclk_phase_gen.sv
// ---------------------------------------------------------------------------
// sclk_phase_gen
//   Generates the serial clock and bit-period framing for the transmitter.
//   Each bit period is 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then
//   high for CLK_DIV cycles. The phase counter sits at 0 with sclk low while
//   run is low, so the first cycle after run rises is always the first cycle
//   of a bit period.
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable, 0 holds all state
//   run        in   frame in progress
//   sclk       out  registered serial clock
//   bit_start  out  high in the first cycle of a bit period
//   bit_end    out  high in the last cycle of a bit period
// ---------------------------------------------------------------------------
module sclk_phase_gen #(
    parameter int CLK_DIV = count_pkg::TX_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    output logic sclk,
    output logic bit_start,
    output logic bit_end
);

    localparam int            DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Half-period counter: counts 0..CLK_DIV-1 and flips sclk on each wrap.
    // Idle keeps it parked at zero with sclk low so every frame starts in
    // phase. When the final bit period ends the wrap itself returns sclk to
    // low, matching the idle state the FSM lands in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (ena) begin
            if (!run) begin
                div_cnt <= '0;
                sclk    <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Bit-period markers decoded from the registered phase state.
    assign bit_start = run && !sclk && (div_cnt == '0);
    assign bit_end   = run &&  sclk && (div_cnt == DIV_LAST);

endmodule

// File: rtl/count_serial_tx.sv
// ---------------------------------------------------------------------------
// count_serial_tx
//   Serial read-out transmitter for the counter value. A start request in
//   idle snapshots count_in and shifts it out MSB-first on a 3-wire link
//   (cs_n, sclk, sdo), optionally followed by an even-parity bit. The
//   receiver samples sdo on the rising edge of sclk. All outputs are
//   registered.
// Parameters
//   WIDTH    data bits per frame (>=1)
//   CLK_DIV  sclk half-period in clk cycles (>=1)
//   PARITY   1 appends an even-parity bit, 0 sends data bits only
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   clock enable, 0 freezes all state and outputs
//   start     in   frame request, sampled while idle
//   count_in  in   value to send, captured on the accept cycle
//   cs_n      out  frame select, low for the whole frame
//   sclk      out  serial clock
//   sdo       out  serial data
//   busy      out  frame in progress
//   done      out  one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------
module count_serial_tx
    import count_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int CLK_DIV = TX_CLK_DIV,
    parameter int PARITY  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] count_in,
    output logic             cs_n,
    output logic             sclk,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    localparam int            NBITS    = WIDTH + ((PARITY != 0) ? 1 : 0);
    localparam int            BW       = $clog2(NBITS) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_DATA_LAST = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic [BW-1:0]    bit_cnt;
    logic             run;
    logic             bit_start;
    logic             bit_end;

    assign run = (state == ST_SHIFT);

    sclk_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .run       (run),
        .sclk      (sclk),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    // Frame FSM with registered outputs.
    // The MSB is put on sdo at accept time so it is valid in the very first
    // shift cycle. At the start of each bit period the shift register moves
    // one place, so by the end of bit k its top bit already holds data bit
    // k+1, which is loaded onto sdo at that boundary. After the last data
    // bit the parity bit (if enabled) is sent instead. The cycle after the
    // last bit period is the idle/done cycle, in which a new start can
    // already be accepted, giving a one-cycle cs_n gap between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        shreg   <= count_in;
                        par     <= ^count_in;
                        bit_cnt <= '0;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        sdo     <= count_in[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    if (bit_start) begin
                        shreg <= shreg << 1;
                    end
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_IDLE;
                            cs_n  <= 1'b1;
                            sdo   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            if ((PARITY != 0) && (bit_cnt == BIT_DATA_LAST)) begin
                                sdo <= par;
                            end else begin
                                sdo <= shreg[WIDTH-1];
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_count_serial_tx
//   Directed bench for count_serial_tx. Two instances share clock, reset,
//   enable and count_in: dut0 sends data only, dut1 appends even parity.
//   Output vectors are packed as {cs_n, sclk, sdo, busy, done}.
// ---------------------------------------------------------------------------
module tb_count_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start0;
    logic       start1;
    logic [7:0] count_in;

    logic cs_n0, sclk0, sdo0, busy0, done0;
    logic cs_n1, sclk1, sdo1, busy1, done1;

    int n_checks;
    int n_pass;
    int n_fail;

    count_serial_tx #(
        .WIDTH   (8),
        .CLK_DIV (4),
        .PARITY  (0)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start0),
        .count_in (count_in),
        .cs_n     (cs_n0),
        .sclk     (sclk0),
        .sdo      (sdo0),
        .busy     (busy0),
        .done     (done0)
    );

    count_serial_tx #(
        .WIDTH   (8),
        .CLK_DIV (4),
        .PARITY  (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start1),
        .count_in (count_in),
        .cs_n     (cs_n1),
        .sclk     (sclk1),
        .sdo      (sdo1),
        .busy     (busy1),
        .done     (done1)
    );

    // Free-running 10-unit system clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setStart(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] value);
        count_in = value;
        setStart(sel, 1'b1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs a fixed window of cycles starting with the accept edge, recording
    // what a receiver would see and applying the scheduled side stimulus.
    task automatic monitorFrame(
        input  bit          sel,
        input  int          cycles,
        input  int          release_at,
        input  int          change_at,
        input  logic [7:0]  new_count,
        input  int          pulse_at,
        input  int          freeze_at,
        input  int          freeze_len,
        input  logic [4:0]  freeze_exp,
        output logic [4:0]  snap0,
        output logic [31:0] rx,
        output int          nrx,
        output int          busy_cycles,
        output int          done_cnt,
        output int          frames,
        output int          gap,
        output int          frozen_errs
    );
        logic [4:0] obs;
        logic       prev_sclk;
        logic       prev_cs;
        int         high_run;
        bit         seen_low;
        snap0       = '0;
        rx          = '0;
        nrx         = 0;
        busy_cycles = 0;
        done_cnt    = 0;
        frames      = 0;
        gap         = -1;
        frozen_errs = 0;
        prev_sclk   = 1'b0;
        prev_cs     = 1'b1;
        high_run    = 0;
        seen_low    = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            obs = sel ? {cs_n1, sclk1, sdo1, busy1, done1}
                      : {cs_n0, sclk0, sdo0, busy0, done0};
            if (c == 0) snap0 = obs;
            if (obs[1]) busy_cycles++;
            if (obs[0]) done_cnt++;
            if (obs[3] && !prev_sclk) begin
                rx = {rx[30:0], obs[2]};
                nrx++;
            end
            if (!obs[4] && prev_cs) begin
                frames++;
                if (seen_low) gap = high_run;
            end
            if (obs[4]) high_run++;
            else begin
                high_run = 0;
                seen_low = 1'b1;
            end
            prev_sclk = obs[3];
            prev_cs   = obs[4];
            if (freeze_at >= 0 && c >= freeze_at && c <= freeze_at + freeze_len
                && obs !== freeze_exp) frozen_errs++;
            if (c == release_at) setStart(sel, 1'b0);
            if (c == change_at) count_in = new_count;
            if (c == pulse_at) setStart(sel, 1'b1);
            if (pulse_at >= 0 && c == pulse_at + 1) setStart(sel, 1'b0);
            if (c == freeze_at) ena = 1'b0;
            if (freeze_at >= 0 && c == freeze_at + freeze_len) ena = 1'b1;
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [4:0]  snap0;
        logic [31:0] rx;
        int          nrx, busy_cycles, done_cnt, frames, gap, frozen_errs;
        int          done_seen;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b1;
        ena      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        count_in = 8'h00;

        $display("[TB] reset");
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_dut0", {27'd0, cs_n0, sclk0, sdo0, busy0, done0}, 32'h10);
        checkOutput("reset_dut1", {27'd0, cs_n1, sclk1, sdo1, busy1, done1}, 32'h10);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", {27'd0, cs_n0, sclk0, sdo0, busy0, done0}, 32'h10);

        $display("[TB] test 1: 0xA5 no parity");
        applyStimulus(1'b0, 8'hA5);
        monitorFrame(1'b0, 70, 0, -1, 8'h00, -1, -1, 0, 5'h00,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t1_first_cycle", {27'd0, snap0}, 32'h06);
        checkOutput("t1_nbits", nrx, 8);
        checkOutput("t1_data", rx & 32'hFF, 32'hA5);
        checkOutput("t1_busy_len", busy_cycles, 64);
        checkOutput("t1_done", done_cnt, 1);
        checkOutput("t1_idle_end", {27'd0, cs_n0, sclk0, sdo0, busy0, done0}, 32'h10);

        $display("[TB] test 2: 0x07 with parity");
        applyStimulus(1'b1, 8'h07);
        monitorFrame(1'b1, 80, 0, -1, 8'h00, -1, -1, 0, 5'h00,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t2_nbits", nrx, 9);
        checkOutput("t2_data_par", rx & 32'h1FF, 32'h00F);
        checkOutput("t2_busy_len", busy_cycles, 72);
        checkOutput("t2_done", done_cnt, 1);

        $display("[TB] test 3: back-to-back frames");
        applyStimulus(1'b0, 8'h01);
        monitorFrame(1'b0, 135, 66, 2, 8'h02, -1, -1, 0, 5'h00,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t3_frames", frames, 2);
        checkOutput("t3_cs_gap", gap, 1);
        checkOutput("t3_nbits", nrx, 16);
        checkOutput("t3_data", rx & 32'hFFFF, 32'h0102);
        checkOutput("t3_done", done_cnt, 2);
        checkOutput("t3_busy_len", busy_cycles, 128);

        $display("[TB] test 4: mid-frame changes ignored");
        applyStimulus(1'b0, 8'h3C);
        monitorFrame(1'b0, 80, 0, 20, 8'hFF, 20, -1, 0, 5'h00,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t4_frames", frames, 1);
        checkOutput("t4_data", rx & 32'hFF, 32'h3C);
        checkOutput("t4_busy_len", busy_cycles, 64);
        checkOutput("t4_done", done_cnt, 1);

        $display("[TB] test 5: ena low for 10 cycles in bit 3");
        applyStimulus(1'b0, 8'h96);
        monitorFrame(1'b0, 90, 0, -1, 8'h00, -1, 25, 10, 5'b00110,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t5_frozen", frozen_errs, 0);
        checkOutput("t5_data", rx & 32'hFF, 32'h96);
        checkOutput("t5_busy_len", busy_cycles, 74);
        checkOutput("t5_done", done_cnt, 1);

        $display("[TB] test 6: reset during bit 5");
        applyStimulus(1'b0, 8'h5A);
        tick();
        setStart(1'b0, 1'b0);
        repeat (45) tick();
        checkOutput("t6_pre_reset", {27'd0, cs_n0, sclk0, sdo0, busy0, done0}, 32'h0A);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset", {27'd0, cs_n0, sclk0, sdo0, busy0, done0}, 32'h10);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0) done_seen++;
        end
        checkOutput("t6_no_done", done_seen, 0);
        applyStimulus(1'b0, 8'hC3);
        monitorFrame(1'b0, 70, 0, -1, 8'h00, -1, -1, 0, 5'h00,
                     snap0, rx, nrx, busy_cycles, done_cnt, frames, gap, frozen_errs);
        checkOutput("t6_fresh_data", rx & 32'hFF, 32'hC3);
        checkOutput("t6_fresh_nbits", nrx, 8);
        checkOutput("t6_fresh_busy", busy_cycles, 64);
        checkOutput("t6_fresh_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
